// File: rtl/receptor_serial_paralelo.sv
// Serial-to-parallel receiver: hunts for the K28.5 comma, locks after LOCK_CNT aligned commas, then emits one 10b symbol every 10 clocks.
// Symbol strobe one edge after its last bit is sampled; no backpressure, the stream is bit-rate paced.
module receptor_serial_paralelo #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned MAX_ERR  = 2,
  parameter logic [9:0]  COMMA_P  = 10'b0011111010,
  parameter logic [9:0]  COMMA_N  = 10'b1100000101
) (
  input  logic       CLK,
  input  logic       RESET_SP,
  input  logic       IN_SERIAL,
  output logic [9:0] SYM_OUT,
  output logic       SYM_VALID,
  output logic       IS_COMMA,
  output logic       LOCK
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [4:0] LOCK_CNT_W = 5'(LOCK_CNT);
  localparam logic [4:0] MAX_ERR_W  = 5'(MAX_ERR);

  state_t     state_q, state_d;
  logic [9:0] shreg;
  logic [3:0] bit_cnt, bit_cnt_d;
  logic [3:0] comma_cnt, comma_cnt_d;
  logic [3:0] err_cnt, err_cnt_d;
  logic       hit, bnd, emit;
  logic [4:0] comma_nxt, err_nxt;

  assign hit       = (shreg == COMMA_P) || (shreg == COMMA_N);
  assign bnd       = (bit_cnt == 4'd9);
  assign comma_nxt = {1'b0, comma_cnt} + 5'd1;
  assign err_nxt   = {1'b0, err_cnt} + 5'd1;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bnd ? 4'd0 : bit_cnt + 4'd1;
    comma_cnt_d = comma_cnt;
    err_cnt_d   = err_cnt;
    emit        = 1'b0;

    case (state_q)
      HUNT: begin
        if (hit) begin
          state_d     = SYNC;
          bit_cnt_d   = 4'd0;
          comma_cnt_d = 4'd1;
        end
      end

      SYNC: begin
        if (bnd && hit) begin
          comma_cnt_d = comma_nxt[3:0];
          // The locking comma is itself the first emitted symbol.
          if (comma_nxt >= LOCK_CNT_W) begin
            state_d = LOCKED;
            emit    = 1'b1;
          end
        end else if (bnd) begin
          state_d     = HUNT;
          comma_cnt_d = 4'd0;
        end else if (hit) begin
          bit_cnt_d   = 4'd0;
          comma_cnt_d = 4'd1;
        end
      end

      LOCKED: begin
        if (bnd) begin
          emit = 1'b1;
          if (hit) err_cnt_d = 4'd0;
        end else if (hit) begin
          // Phase is never re-aligned while locked; repeated off-boundary commas drop lock instead.
          if (err_nxt >= MAX_ERR_W) begin
            state_d   = HUNT;
            err_cnt_d = 4'd0;
          end else begin
            err_cnt_d = err_nxt[3:0];
          end
        end
      end

      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_SP) begin
    if (!RESET_SP) begin
      state_q   <= HUNT;
      shreg     <= '0;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      err_cnt   <= '0;
      SYM_OUT   <= '0;
      SYM_VALID <= 1'b0;
      IS_COMMA  <= 1'b0;
      LOCK      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg     <= {shreg[8:0], IN_SERIAL};
      bit_cnt   <= bit_cnt_d;
      comma_cnt <= comma_cnt_d;
      err_cnt   <= err_cnt_d;
      SYM_VALID <= emit;
      LOCK      <= (state_d == LOCKED);
      if (emit) begin
        SYM_OUT  <= shreg;
        IS_COMMA <= hit;
      end
    end
  end

endmodule
